i2s_fifo_ctrl: RTL

Sequencer for the 8-entry × 32-bit clock-strobed transmit FIFO (`fifo328`) in the I2S interface. It owns the FIFO's `fill` and `drain` strobes and arbitrates round-robin between host pushes and I2S frame-side pops. It turns requests into properly spaced strobe pulses and captures popped words. It also provides flush, depth configuration, sticky overflow/underflow flags and a low-watermark interrupt.

---
 rtl/i2s_fifo_ctrl_pkg.sv | 15 +
 rtl/i2s_fifo_arb.sv | 46 ++++
 rtl/i2s_fifo_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/i2s_fifo_ctrl_pkg.sv
// i2s_fifo_ctrl_pkg: shared state encoding and defaults for the I2S transmit FIFO sequencer
package i2s_fifo_ctrl_pkg;
    localparam int DW_DEF    = 32;
    localparam int AW_DEF    = 3;
    localparam int DEPTH_DEF = 7;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_DRAIN  = 3'd2,
        S_CAPT   = 3'd3,
        S_FLUSH  = 3'd4,
        S_FDRAIN = 3'd5
    } state_t;
endpackage

// File: rtl/i2s_fifo_arb.sv
// i2s_fifo_arb: push/pop pending latches with round-robin grant and loss/merge detection
module i2s_fifo_arb
    import i2s_fifo_ctrl_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          host_wr,
    input  logic [DW-1:0] host_wdata,
    input  logic          i2s_req,
    input  logic          en,
    input  logic          wr_ok,
    input  logic          drop_wr,
    input  logic          rd_done,
    output logic          wr_pend,
    output logic [DW-1:0] wr_data,
    output logic          rd_pend,
    output logic          gnt_wr,
    output logic          gnt_rd,
    output logic          ovf_set,
    output logic          udr_set
);
    logic prio_rd;

    // a blocked write (FIFO full) falls through to the read side
    assign gnt_wr  = en & wr_pend & wr_ok & (~rd_pend | ~prio_rd);
    assign gnt_rd  = en & rd_pend & ~gnt_wr;
    assign ovf_set = host_wr & wr_pend;
    assign udr_set = i2s_req & rd_pend;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_pend <= 1'b0;
            wr_data <= '0;
            rd_pend <= 1'b0;
            prio_rd <= 1'b1;
        end else begin
            wr_pend <= (wr_pend & ~gnt_wr & ~drop_wr) | (host_wr & ~wr_pend);
            if (host_wr & ~wr_pend) wr_data <= host_wdata;
            rd_pend <= (rd_pend & ~rd_done) | (i2s_req & ~rd_pend);
            if (gnt_wr) prio_rd <= 1'b1;
            else if (gnt_rd) prio_rd <= 1'b0;
        end
    end
endmodule

// File: rtl/i2s_fifo_ctrl.sv
// i2s_fifo_ctrl: strobe sequencer for the clock-strobed I2S transmit FIFO
module i2s_fifo_ctrl
    import i2s_fifo_ctrl_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          host_wr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_wready,
    input  logic          i2s_req,
    output logic [DW-1:0] i2s_rdata,
    output logic          i2s_rvalid,
    input  logic          flush,
    output logic          flush_done,
    input  logic [AW-1:0] cfg_depth,
    input  logic [AW-1:0] wm,
    input  logic          irq_en,
    input  logic          clr_flags,
    output logic          ovf,
    output logic          udr,
    output logic          irq,
    output logic          fifo_fill,
    output logic          fifo_drain,
    output logic [DW-1:0] fifo_d,
    output logic [AW-1:0] fifo_depth,
    input  logic [DW-1:0] fifo_q,
    input  logic          fifo_full,
    input  logic          fifo_empty,
    input  logic [AW-1:0] fifo_count
);
    state_t state;
    logic   idle, flush_pend, wr_pend, rd_pend, gnt_wr, gnt_rd, ovf_set, udr_set;

    assign idle        = state == S_IDLE;
    assign host_wready = ~wr_pend;

    // fifo_d is the push holding register itself, so it is settled a cycle ahead of fifo_fill
    i2s_fifo_arb #(.DW(DW)) u_arb (
        .clk        (clk),
        .rstn       (rstn),
        .host_wr    (host_wr),
        .host_wdata (host_wdata),
        .i2s_req    (i2s_req),
        .en         (idle & ~flush_pend),
        .wr_ok      (~fifo_full),
        .drop_wr    (idle & flush_pend),
        .rd_done    ((gnt_rd & fifo_empty) | (state == S_DRAIN)),
        .wr_pend    (wr_pend),
        .wr_data    (fifo_d),
        .rd_pend    (rd_pend),
        .gnt_wr     (gnt_wr),
        .gnt_rd     (gnt_rd),
        .ovf_set    (ovf_set),
        .udr_set    (udr_set)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            flush_pend <= 1'b0;
            fifo_fill  <= 1'b0;
            fifo_drain <= 1'b0;
            fifo_depth <= AW'(DEPTH_DEF);
            i2s_rdata  <= '0;
            i2s_rvalid <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            fifo_fill  <= 1'b0;
            fifo_drain <= 1'b0;
            i2s_rvalid <= 1'b0;
            flush_done <= 1'b0;
            flush_pend <= flush | (flush_pend & ~idle);
            case (state)
                S_IDLE: begin
                    fifo_depth <= cfg_depth;
                    if (flush_pend) begin
                        state <= S_FLUSH;
                    end else if (gnt_wr) begin
                        fifo_fill <= 1'b1;
                        state     <= S_FILL;
                    end else if (gnt_rd && fifo_empty) begin
                        i2s_rdata  <= '0;
                        i2s_rvalid <= 1'b1;
                    end else if (gnt_rd) begin
                        fifo_drain <= 1'b1;
                        state      <= S_DRAIN;
                    end
                end
                S_FILL: state <= S_IDLE;
                S_DRAIN: begin
                    i2s_rdata  <= fifo_q;
                    i2s_rvalid <= 1'b1;
                    state      <= S_CAPT;
                end
                S_CAPT: state <= S_IDLE;
                S_FLUSH: begin
                    if (fifo_empty) begin
                        flush_done <= 1'b1;
                        state      <= S_IDLE;
                    end else begin
                        fifo_drain <= 1'b1;
                        state      <= S_FDRAIN;
                    end
                end
                S_FDRAIN: state <= S_FLUSH;
                default:  state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf <= 1'b0;
            udr <= 1'b0;
            irq <= 1'b0;
        end else begin
            ovf <= ovf_set | (ovf & ~clr_flags);
            udr <= udr_set | (gnt_rd & fifo_empty) | (udr & ~clr_flags);
            irq <= (irq_en & (fifo_count <= wm)) | ovf | udr;
        end
    end
endmodule
